// File: rtl/bit_serial_add_seq_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
//   Shared types and constants for the bit-serial adder slice.
//   - state_e       : control FSM states (IDLE, SHIFT, DONE)
//   - DEFAULT_WIDTH : default operand/sum width
//   - majority()    : carry function of a full adder
// Optional feature macro used elsewhere in this slice: SERIAL_ADD_SUB_EN
// -----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Carry out of a full adder: true when at least two inputs are set.
  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/bit_serial_add_seq_if.sv
// -----------------------------------------------------------------------------
// bit_serial_add_seq_if
//   Request/result bundle of the bit-serial adder.
//   Requester -> adder : start, a, b, cin (and sub when SERIAL_ADD_SUB_EN)
//   Adder -> requester : ready, busy, done, sum, cout
//   Modports: master (requester side), slave (adder side).
// Optional feature macro: SERIAL_ADD_SUB_EN adds the 1-bit 'sub' request.
// -----------------------------------------------------------------------------
interface bit_serial_add_seq_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADD_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADD_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/bit_serial_add_seq_fa_cell.sv
// -----------------------------------------------------------------------------
// serial_fa_cell
//   One full-adder cell with its carry held in a flip-flop, so that a
//   multi-bit add can be done one bit per clock.
// Ports:
//   Clk, ClrN    : clock, asynchronous active-low clear of the carry
//   load         : load load_carry into the carry flop (start of an add)
//   load_carry   : initial carry value
//   shift_en     : advance one bit: carry flop takes carry_next
//   a_bit, b_bit : current operand bits
//   sum_bit      : a_bit ^ b_bit ^ carry (combinational)
//   carry_next   : carry produced by the current bit (combinational)
// -----------------------------------------------------------------------------
module serial_fa_cell
  import serial_add_pkg::*;
(
  input  logic Clk,
  input  logic ClrN,
  input  logic load,
  input  logic load_carry,
  input  logic shift_en,
  input  logic a_bit,
  input  logic b_bit,
  output logic sum_bit,
  output logic carry_next
);

  logic carry_q;
  logic carry_d;

  always_comb begin
    sum_bit    = a_bit ^ b_bit ^ carry_q;
    carry_next = majority(a_bit, b_bit, carry_q);
    carry_d    = carry_q;
    if (load) begin
      carry_d = load_carry;
    end else if (shift_en) begin
      carry_d = carry_next;
    end
  end

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/bit_serial_add_seq.sv
// -----------------------------------------------------------------------------
// bit_serial_add_seq
//   Sequential bit-serial adder. Operands are captured on an accepted start
//   and added LSB-first through a single full-adder cell, one bit per clock.
//   The result is presented on sum/cout together with a one-cycle done pulse
//   and held until the next result replaces it.
// Parameters:
//   WIDTH : operand/sum width, 2..32
// Ports:
//   Clk  : clock, all state changes on posedge
//   ClrN : asynchronous active-low reset
//   bus  : bit_serial_add_seq_if.slave
//          start/a/b/cin(/sub) in, ready/busy/done/sum/cout out
// Optional feature macro: SERIAL_ADD_SUB_EN
//   Adds bus.sub. With sub=1 the captured b is inverted and the carry starts
//   at 1, giving sum = a - b; cout=1 then means "no borrow".
// -----------------------------------------------------------------------------
module bit_serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic                 Clk,
  input  logic                 ClrN,
  bit_serial_add_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the first WIDTH-1 sum bits; the last bit goes straight to sum_q.
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] b_load;
  logic             carry_init;
  logic             load;
  logic             shift_en;
  logic             s_bit;
  logic             carry_next;
  logic [WIDTH-1:0] sum_shifted;

  // Operand conditioning at capture time.
  always_comb begin
`ifdef SERIAL_ADD_SUB_EN
    b_load     = bus.sub ? ~bus.b : bus.b;
    carry_init = bus.sub ? 1'b1 : bus.cin;
`else
    b_load     = bus.b;
    carry_init = bus.cin;
`endif
  end

  serial_fa_cell u_fa (
    .Clk        (Clk),
    .ClrN       (ClrN),
    .load       (load),
    .load_carry (carry_init),
    .shift_en   (shift_en),
    .a_bit      (a_sh_q[0]),
    .b_bit      (b_sh_q[0]),
    .sum_bit    (s_bit),
    .carry_next (carry_next)
  );

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    load        = 1'b0;
    shift_en    = 1'b0;
    // New bit enters at the MSB; after WIDTH shifts bit 0 is the LSB result.
    sum_shifted = {s_bit, sum_sh_q};

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = SHIFT;
          a_sh_d   = bus.a;
          b_sh_d   = b_load;
          sum_sh_d = '0;
          cnt_d    = '0;
          load     = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end

      SHIFT: begin
        shift_en = 1'b1;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shifted[WIDTH-1:1];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = sum_shifted;
          cout_d  = carry_next;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  // Status decodes straight from the state register so an asynchronous
  // reset is visible on the outputs without waiting for a clock edge.
  always_comb begin
    bus.ready = (state_q == IDLE) || (state_q == DONE);
    bus.busy  = (state_q == SHIFT);
    bus.done  = (state_q == DONE);
    bus.sum   = sum_q;
    bus.cout  = cout_q;
  end

endmodule

// File: tb/tb_bit_serial_add_seq.sv
// -----------------------------------------------------------------------------
// tb_bit_serial_add_seq
//   Self-checking bench for bit_serial_add_seq (WIDTH = 4). A cycle-indexed
//   reference model predicts ready/busy/done/sum/cout every cycle; directed
//   operations also check literal results and latency.
// Optional feature macro: SERIAL_ADD_SUB_EN (enables subtract cases).
// -----------------------------------------------------------------------------
module tb_bit_serial_add_seq;

  localparam int W = serial_add_pkg::DEFAULT_WIDTH;

  logic Clk  = 1'b0;
  logic ClrN = 1'b0;
  always #5 Clk = ~Clk;

  bit_serial_add_seq_if #(.WIDTH(W)) bus_if ();

  bit_serial_add_seq #(.WIDTH(W)) dut (
    .Clk  (Clk),
    .ClrN (ClrN),
    .bus  (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W:0] t;
    if (s) t = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    return t;
  endfunction

  function automatic logic cur_sub();
`ifdef SERIAL_ADD_SUB_EN
    return bus_if.sub;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: an op accepted at the edge starting cycle k is busy in
  // cycles k..k+W-1 and done in cycle k+W, when its result becomes visible.
  bit         m_inflight;
  int         m_k;
  int         m_cyc;
  logic [W:0] m_pending;
  logic [W-1:0] m_sum;
  logic       m_cout;

  initial begin
    logic rdy;
    m_inflight = 0; m_k = 0; m_cyc = 0; m_pending = '0; m_sum = '0; m_cout = 0;
    forever begin
      @(posedge Clk);
      if (!ClrN) begin
        m_inflight = 0; m_sum = '0; m_cout = 0;
      end else begin
        rdy = !m_inflight || (m_cyc >= m_k + W);
        m_cyc++;
        if (rdy && bus_if.start) begin
          m_inflight = 1;
          m_k        = m_cyc;
          m_pending  = ref_add(bus_if.a, bus_if.b, bus_if.cin, cur_sub());
        end
        if (m_inflight && m_cyc == m_k + W) begin
          m_sum  = m_pending[W-1:0];
          m_cout = m_pending[W];
        end
      end
      @(negedge Clk);
      if (!ClrN) begin
        m_inflight = 0; m_sum = '0; m_cout = 0;
      end
      chk("ready", bus_if.ready, !m_inflight || (m_cyc >= m_k + W));
      chk("busy",  bus_if.busy,  m_inflight && (m_cyc < m_k + W));
      chk("done",  bus_if.done,  m_inflight && (m_cyc == m_k + W));
      chk("sum",   bus_if.sum,   m_sum);
      chk("cout",  bus_if.cout,  m_cout);
      if (bus_if.done) begin
        txn++;
        $display("txn %0d: sum=%0d cout=%0d", txn, bus_if.sum, bus_if.cout);
      end
    end
  end

  task automatic set_inputs(input logic st, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic s);
    bus_if.start = st;
    bus_if.a     = x;
    bus_if.b     = y;
    bus_if.cin   = ci;
`ifdef SERIAL_ADD_SUB_EN
    bus_if.sub   = s;
`else
    if (s) $display("note: sub request ignored in add-only build");
`endif
  endtask

  // Wait (at negedges) for done; returns cycles waited, or -1 on timeout.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 0; i < 4 * W; i++) begin
      if (bus_if.done) begin
        cycles = i;
        break;
      end
      @(negedge Clk);
    end
    if (cycles < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic s,
                        input logic [W-1:0] exp_sum, input logic exp_cout);
    int cyc;
    @(negedge Clk);
    set_inputs(1'b1, x, y, ci, s);
    @(negedge Clk);
    // Scramble operands after acceptance: they must have no effect.
    set_inputs(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    wait_done(cyc);
    chk({name, "_latency"}, cyc, W);
    chk({name, "_sum"}, bus_if.sum, exp_sum);
    chk({name, "_cout"}, bus_if.cout, exp_cout);
  endtask

  initial begin
    int cyc;
    int gap;
    set_inputs(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge Clk);
    #1 ClrN = 1'b1;

    // Basic add and carry-out cases.
    run_op("add_5_3",   4'd5,  4'd3, 1'b0, 1'b0, 4'd8, 1'b0);
    run_op("add_15_1",  4'd15, 4'd1, 1'b0, 1'b0, 4'd0, 1'b1);
    run_op("add_9_7_c", 4'd9,  4'd7, 1'b1, 1'b0, 4'd1, 1'b1);

    // Start while busy must be ignored.
    @(negedge Clk);
    set_inputs(1'b1, 4'd2, 4'd2, 1'b0, 1'b0);
    @(negedge Clk);
    set_inputs(1'b1, 4'd7, 4'd7, 1'b0, 1'b0);
    chk("busy_start_ready0", bus_if.ready, 0);
    @(negedge Clk);
    chk("busy_start_ready1", bus_if.ready, 0);
    @(negedge Clk);
    bus_if.start = 1'b0;
    wait_done(cyc);
    chk("busy_start_sum", bus_if.sum, 4);
    chk("busy_start_cout", bus_if.cout, 0);

    // Back-to-back with start held high.
    @(negedge Clk);
    set_inputs(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
    @(negedge Clk);
    set_inputs(1'b1, 4'd6, 4'd9, 1'b0, 1'b0);
    wait_done(cyc);
    chk("b2b_first_sum", bus_if.sum, 2);
    chk("b2b_first_cout", bus_if.cout, 0);
    gap = 0;
    do begin
      @(negedge Clk);
      gap++;
    end while (!bus_if.done && gap < 4 * W);
    bus_if.start = 1'b0;
    chk("b2b_gap", gap, W + 1);
    chk("b2b_second_sum", bus_if.sum, 15);
    chk("b2b_second_cout", bus_if.cout, 0);

    // Asynchronous reset during the second SHIFT cycle.
    @(negedge Clk);
    set_inputs(1'b1, 4'd3, 4'd6, 1'b0, 1'b0);
    @(posedge Clk);
    @(negedge Clk);
    bus_if.start = 1'b0;
    @(posedge Clk);
    #2 ClrN = 1'b0;
    #1;
    chk("rst_ready", bus_if.ready, 1);
    chk("rst_busy",  bus_if.busy, 0);
    chk("rst_done",  bus_if.done, 0);
    chk("rst_sum",   bus_if.sum, 0);
    chk("rst_cout",  bus_if.cout, 0);
    @(negedge Clk);
    #1 ClrN = 1'b1;
    run_op("after_rst_4_4", 4'd4, 4'd4, 1'b0, 1'b0, 4'd8, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("sub_3_5", 4'd3, 4'd5, 1'b0, 1'b1, 4'd14, 1'b0);
    run_op("sub_9_4", 4'd9, 4'd4, 1'b0, 1'b1, 4'd5,  1'b1);
`endif

    // Randomized traffic, checked cycle by cycle by the model.
    repeat (400) begin
      @(negedge Clk);
      set_inputs($urandom_range(0, 2) != 0, W'($urandom), W'($urandom),
                 1'($urandom), 1'($urandom));
    end
    @(negedge Clk);
    bus_if.start = 1'b0;
    repeat (2 * W + 2) @(negedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
